sync_fifo_param: RTL

//  Parametrised single-clock FIFO, successor to the fixed 16x8 FIFO under verification.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and sizing helper for the parametrised FIFO
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous read port
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    import fifo_pkg::*;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with selectable FWFT output, flush, margins and occupancy count
module sync_fifo_param #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEF_DEPTH,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int FWFT       = 0,
    localparam int CNT_W     = fifo_pkg::cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);
    import fifo_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : STD;

    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AF_MARGIN >= DEPTH) begin : g_chk_af
        $error("sync_fifo_param: AF_MARGIN must be < DEPTH");
    end
    if (AE_MARGIN >= DEPTH) begin : g_chk_ae
        $error("sync_fifo_param: AE_MARGIN must be < DEPTH");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_we;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (cnt_q == CNT_W'(DEPTH));
    assign empty       = (cnt_q == '0);
    assign almostfull  = (cnt_q >= CNT_W'(DEPTH - AF_MARGIN)) && !full;
    assign almostempty = !empty && (cnt_q <= CNT_W'(AE_MARGIN));
    assign count       = cnt_q;

    // A read on a full FIFO frees the slot the same-cycle write needs.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign mem_we = wr_acc && !rst && !flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && empty;
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr     <= next_ptr(rd_ptr);
                data_out_q <= rd_data;
            end
            valid_q <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_out = (MODE == fifo_pkg::FWFT) ? (empty ? '0 : rd_data) : data_out_q;
    assign valid    = (MODE == fifo_pkg::FWFT) ? !empty : valid_q;

endmodule
